// File: rtl/mul_arb_pkg.sv
// Shared helpers for the multiplier-sharing arbiter: width functions and the
// round-robin pick.
package mul_arb_pkg;

  localparam int unsigned MAX_REQ = 16;
  localparam int unsigned IDX_W   = 4;

  // Tag width for n requesters (at least one bit)
  function automatic int unsigned tag_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // FIFO pointer width for a depth of n entries (at least one bit)
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First valid index after ptr, wrapping over n requesters; ptr when none valid
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                               input logic [IDX_W-1:0]   ptr,
                                               input int unsigned        n);
    int unsigned idx;
    logic        found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      idx = (32'(ptr) + k) % n;
      if (!found && (k <= n) && valid[idx[IDX_W-1:0]]) begin
        rr_pick = IDX_W'(idx);
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mul_arb_tag_fifo.sv
// In-order owner-tag FIFO; one entry per product in flight in the multiplier.
module mul_arb_tag_fifo
  import mul_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DW-1:0]                 din,
  output logic [DW-1:0]                 dout,
  output logic                          full,
  output logic                          empty,
  output logic [ptr_width(DEPTH):0]     count
);

  localparam int unsigned AW    = ptr_width(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push_c;
  logic          do_pop_c;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_push_c = push && !full;
  assign do_pop_c  = pop && !empty;
  assign dout      = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define contents
  always_ff @(posedge clk) begin
    if (do_push_c) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push_c) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      end
      if (do_pop_c) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      end
      case ({do_push_c, do_pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one pipelined multiplier among N_REQ requesters.
// Optional issue/stall counters are built when MUL_ARB_STATS_EN is defined.
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]       mul_a,
  output logic [WIDTH-1:0]       mul_b,
  output logic                   mul_do,
  input  logic [2*WIDTH-1:0]     mul_p,
  input  logic                   mul_done,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [2*WIDTH-1:0]     rsp_data,
  output logic                   busy,
`ifdef MUL_ARB_STATS_EN
  output logic [31:0]            stat_issue,
  output logic [31:0]            stat_stall,
`endif
  output logic                   err_orphan
);

  localparam int unsigned TAG_W = tag_width(N_REQ);
  localparam int unsigned PTR_W = ptr_width(MAX_OUT);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [TAG_W-1:0] ptr;
  logic [TAG_W-1:0] gnt_idx_c;
  logic [TAG_W-1:0] head_tag;
  logic [WIDTH-1:0] sel_a_c;
  logic [WIDTH-1:0] sel_b_c;
  logic             accept_c;
  logic             pop_c;
  logic             orphan_c;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // Grant: next valid requester after the last winner, only while a tag slot is free
  always_comb begin
    gnt_idx_c = TAG_W'(rr_pick(MAX_REQ'(req_valid), IDX_W'(ptr), N_REQ));
    req_ready = '0;
    if (!fifo_full && (|req_valid)) begin
      req_ready = N_REQ'(1) << gnt_idx_c;
    end
  end

  always_comb begin
    sel_a_c = '0;
    sel_b_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (TAG_W'(i) == gnt_idx_c) begin
        sel_a_c = req_a[i*WIDTH +: WIDTH];
        sel_b_c = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign accept_c = |(req_valid & req_ready);
  assign pop_c    = mul_done && !fifo_empty;
  assign orphan_c = mul_done && fifo_empty;
  assign busy     = (fifo_count != '0) || mul_do;

  mul_arb_tag_fifo #(
    .DEPTH (MAX_OUT),
    .DW    (TAG_W)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept_c),
    .pop   (pop_c),
    .din   (gnt_idx_c),
    .dout  (head_tag),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Issue stage: capture the winner's operands and strobe the multiplier next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr    <= TAG_W'(N_REQ - 1);
      mul_a  <= '0;
      mul_b  <= '0;
      mul_do <= 1'b0;
    end else begin
      mul_do <= accept_c;
      if (accept_c) begin
        ptr   <= gnt_idx_c;
        mul_a <= sel_a_c;
        mul_b <= sel_b_c;
      end
    end
  end

  // Return stage: route each product to the owner at the head of the tag FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid  <= '0;
      rsp_data   <= '0;
      err_orphan <= 1'b0;
    end else begin
      rsp_valid <= pop_c ? (N_REQ'(1) << head_tag) : '0;
      if (pop_c) begin
        rsp_data <= mul_p;
      end
      if (orphan_c) begin
        err_orphan <= 1'b1;
      end
    end
  end

`ifdef MUL_ARB_STATS_EN
  logic stall_c;
  assign stall_c = (|req_valid) && fifo_full && !mul_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_issue <= '0;
      stat_stall <= '0;
    end else begin
      if (accept_c) begin
        stat_issue <= stat_issue + 32'd1;
      end
      if (stall_c) begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
Round-robin arbiter that shares one pipelined WIDTHxWIDTH Vedic multiplier between N_REQ requesters in the matrix multiplier.
- Accepts operand pairs from the requesters and drives the multiplier's input-stage do strobe and operands.
- Tracks the owner of each in-flight product in an in-order tag FIFO.
- Routes each product back to its owner as a one-cycle response pulse.

Parameters:
N_REQ, 4, number of requesters (2..16)
WIDTH, 32, operand width; product is 2*WIDTH
MAX_OUT, 4, max products in flight (tag FIFO depth, power of two, >= multiplier latency)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  N_REQ  per-requester operand-pair valid
req_a  in  N_REQ*WIDTH  operand A; requester i uses slice [i*WIDTH +: WIDTH]
req_b  in  N_REQ*WIDTH  operand B; same slicing as req_a
req_ready  out  N_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high
mul_a  out  WIDTH  registered operand A to the multiplier
mul_b  out  WIDTH  registered operand B to the multiplier
mul_do  out  1  one-cycle issue strobe to the multiplier input stage
mul_p  in  2*WIDTH  product from the multiplier
mul_done  in  1  product-valid pulse from the multiplier
rsp_valid  out  N_REQ  one-hot, one-cycle response pulse
rsp_data  out  2*WIDTH  product; valid when any rsp_valid bit is high
busy  out  1  high while the tag FIFO is non-empty or mul_do is high
err_orphan  out  1  sticky; mul_done arrived while the tag FIFO was empty

Behaviour:
- Reset values: req_ready=0, mul_do=0, mul_a=0, mul_b=0, rsp_valid=0, rsp_data=0, err_orphan=0. Tag FIFO empty. RR pointer = N_REQ-1, so requester 0 has first priority.
- Grant (combinational):
  - If outstanding count < MAX_OUT, req_ready gets exactly one bit: the first requester with req_valid high, scanning from ptr+1 with wrap-around.
  - Otherwise req_ready = 0.
- Accept cycle T:
  - At the T edge: ptr <= granted index; mul_a/mul_b <= that requester's slices; tag (granted index) pushed into the FIFO.
  - mul_do = 1 during cycle T+1 only.
  - Back-to-back accepts are allowed, giving one issue per cycle.
- Return:
  - On mul_done, pop the head tag h.
  - Next cycle: rsp_valid = one-hot(h), rsp_data = mul_p registered. Latency is 1 cycle from mul_done.
  - rsp_valid has no backpressure; the owner must take the pulse.
- Outstanding count:
  - +1 on accept, -1 on pop, unchanged when both happen in the same cycle.
  - Count is MAX_OUT only when the FIFO is full. Full blocks all grants, even if mul_done is high in that cycle.
- Orphan case: mul_done with the FIFO empty sets err_orphan (cleared only by reset). No pop, rsp_valid stays 0.
- Products are assumed in issue order (fixed-latency multiplier). No reordering.
- Single requester: a continuously valid requester gets a grant every cycle until the FIFO is full.
- Fairness: with all requesters valid, grants rotate 0,1,2,...,N_REQ-1,0.
- Reset mid-operation:
  - FIFO, count, pointer and outputs return to reset values.
  - In-flight products are discarded.
  - The multiplier is reset by the same signal. Any stray mul_done after reset sets err_orphan.
- Priority: reset has priority over all events.

Optional Feature:
Macro MUL_ARB_STATS_EN.
- Defined:
  - Output port stat_issue [32] counts accepts.
  - Output port stat_stall [32] counts cycles where req_valid is nonzero, count == MAX_OUT, and mul_done is low.
  - Both counters wrap at 2^32 and clear on reset.
- Undefined: neither port nor the counters exist. All other behaviour is identical.

Decomposition:
- Package mul_arb_pkg holds:
  - localparam TAG_W = $clog2(N_REQ) (computed per instance; the package holds a clog2-based function)
  - localparam PTR_W = $clog2(MAX_OUT)
  - function rr_pick(valid, ptr), returning the next index after ptr with wrap-around
- One sub-module: mul_arb_tag_fifo.
  - Synchronous FIFO, depth MAX_OUT, width TAG_W.
  - Ports: push, pop, din, dout, full, empty, count.
  - Simultaneous push and pop are legal when not full and not empty.

Test Plan:
- Round-robin: N_REQ=4, all req_valid=1, mul_done returned 3 cycles after each mul_do -> grants 0,1,2,3,0; each rsp_valid matches its owner; rsp_data = a*b (e.g. 0xFFFFFFFF*0xFFFFFFFF=0xFFFFFFFE00000001).
- Full stall: multiplier never returns; requester 2 valid -> exactly 4 accepts, then req_ready=0. One mul_done -> one more grant on the following cycle.
- Simultaneous push/pop at count=2: accept and mul_done in the same cycle -> count stays 2; response goes to the oldest tag.
- Orphan: after reset, pulse mul_done with no issue -> err_orphan=1 and stays set, rsp_valid=0.
- Reset mid-flight: 3 outstanding, assert reset 1 cycle -> busy=0, FIFO empty. Next grant goes to requester 0 when all are valid.
- MUL_ARB_STATS_EN: 10 accepts and 5 full-stall cycles -> stat_issue=10, stat_stall=5. Reset -> both 0.
